// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - decode, register-file and forwarding bus into the ALU operand stage
interface alu_operand_stage_if #(
  parameter int NB_DATA      = 32,
  parameter int NB_OPERATION = 4,
  parameter int NB_REG_ADDR  = 5,
  parameter int NB_IMM       = 16
);
  logic                    i_valid;
  logic [5:0]              i_opcode;
  logic [5:0]              i_funct;
  logic [4:0]              i_shamt;
  logic [NB_REG_ADDR-1:0]  i_rs_addr;
  logic [NB_REG_ADDR-1:0]  i_rt_addr;
  logic [NB_REG_ADDR-1:0]  i_rd_addr;
  logic [NB_DATA-1:0]      i_rs_data;
  logic [NB_DATA-1:0]      i_rt_data;
  logic [NB_IMM-1:0]       i_imm;
  logic                    i_stall;
  logic                    i_flush;
  logic                    i_exmem_wr_en;
  logic [NB_REG_ADDR-1:0]  i_exmem_rd_addr;
  logic [NB_DATA-1:0]      i_exmem_result;
  logic                    i_memwb_wr_en;
  logic [NB_REG_ADDR-1:0]  i_memwb_rd_addr;
  logic [NB_DATA-1:0]      i_memwb_result;
  logic [NB_DATA-1:0]      o_data_a;
  logic [NB_DATA-1:0]      o_data_b;
  logic [NB_OPERATION-1:0] o_op;
  logic                    o_valid;
  logic                    o_wb_en;
  logic [NB_REG_ADDR-1:0]  o_wb_addr;
  logic                    o_illegal;

  modport master (
    output i_valid, i_opcode, i_funct, i_shamt, i_rs_addr, i_rt_addr, i_rd_addr,
           i_rs_data, i_rt_data, i_imm, i_stall, i_flush,
           i_exmem_wr_en, i_exmem_rd_addr, i_exmem_result,
           i_memwb_wr_en, i_memwb_rd_addr, i_memwb_result,
    input  o_data_a, o_data_b, o_op, o_valid, o_wb_en, o_wb_addr, o_illegal
  );

  modport slave (
    input  i_valid, i_opcode, i_funct, i_shamt, i_rs_addr, i_rt_addr, i_rd_addr,
           i_rs_data, i_rt_data, i_imm, i_stall, i_flush,
           i_exmem_wr_en, i_exmem_rd_addr, i_exmem_result,
           i_memwb_wr_en, i_memwb_rd_addr, i_memwb_result,
    output o_data_a, o_data_b, o_op, o_valid, o_wb_en, o_wb_addr, o_illegal
  );
endinterface

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with ALU op decode, operand select and EX/MEM, MEM/WB forwarding
module alu_operand_stage #(
  parameter int NB_DATA      = 32,
  parameter int NB_OPERATION = 4,
  parameter int NB_REG_ADDR  = 5,
  parameter int NB_IMM       = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  alu_operand_stage_if.slave  bus
);
  typedef logic [NB_OPERATION-1:0] op_t;
  localparam op_t OP_ADD = op_t'(4'b0000);
  localparam op_t OP_SUB = op_t'(4'b0001);
  localparam op_t OP_AND = op_t'(4'b0010);
  localparam op_t OP_OR  = op_t'(4'b0011);
  localparam op_t OP_XOR = op_t'(4'b0100);
  localparam op_t OP_NOR = op_t'(4'b0101);
  localparam op_t OP_SRL = op_t'(4'b0110);
  localparam op_t OP_SLL = op_t'(4'b0111);
  localparam op_t OP_SRA = op_t'(4'b1000);
  localparam op_t OP_SLT = op_t'(4'b1010);
  localparam op_t OP_LUI = op_t'(4'b1011);

  typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT} b_src_t;

  logic                   dec_legal;
  op_t                    dec_op;
  logic                   dec_a_shamt;
  b_src_t                 dec_b_src;
  logic                   dec_wb;
  logic [NB_REG_ADDR-1:0] dec_wb_addr;

  always_comb begin
    dec_legal   = 1'b1;
    dec_op      = OP_ADD;
    dec_a_shamt = 1'b0;
    dec_b_src   = B_RT;
    dec_wb      = 1'b1;
    dec_wb_addr = bus.i_rt_addr;
    case (bus.i_opcode)
      6'h00: begin
        dec_wb_addr = bus.i_rd_addr;
        case (bus.i_funct)
          6'h20, 6'h21: dec_op = OP_ADD;
          6'h22, 6'h23: dec_op = OP_SUB;
          6'h24:        dec_op = OP_AND;
          6'h25:        dec_op = OP_OR;
          6'h26:        dec_op = OP_XOR;
          6'h27:        dec_op = OP_NOR;
          6'h2A:        dec_op = OP_SLT;
          6'h00: begin dec_op = OP_SLL; dec_a_shamt = 1'b1; end
          6'h02: begin dec_op = OP_SRL; dec_a_shamt = 1'b1; end
          6'h03: begin dec_op = OP_SRA; dec_a_shamt = 1'b1; end
          6'h04:        dec_op = OP_SLL;
          6'h06:        dec_op = OP_SRL;
          6'h07:        dec_op = OP_SRA;
          default: begin dec_legal = 1'b0; dec_wb = 1'b0; end
        endcase
      end
      6'h08, 6'h09, 6'h23: begin dec_op = OP_ADD; dec_b_src = B_SEXT; end
      6'h0A: begin dec_op = OP_SLT; dec_b_src = B_SEXT; end
      6'h0C: begin dec_op = OP_AND; dec_b_src = B_ZEXT; end
      6'h0D: begin dec_op = OP_OR;  dec_b_src = B_ZEXT; end
      6'h0E: begin dec_op = OP_XOR; dec_b_src = B_ZEXT; end
      6'h0F: begin dec_op = OP_LUI; dec_b_src = B_ZEXT; end
      6'h2B: begin dec_op = OP_ADD; dec_b_src = B_SEXT; dec_wb = 1'b0; end
      6'h04, 6'h05: begin dec_op = OP_SUB; dec_wb = 1'b0; end
      default: begin dec_legal = 1'b0; dec_wb = 1'b0; end
    endcase
  end

  logic                   valid_q;
  logic                   illegal_q;
  op_t                    op_q;
  logic                   a_shamt_q;
  b_src_t                 b_src_q;
  logic                   wb_en_q;
  logic [NB_REG_ADDR-1:0] wb_addr_q;
  logic [NB_REG_ADDR-1:0] rs_addr_q;
  logic [NB_REG_ADDR-1:0] rt_addr_q;
  logic [NB_DATA-1:0]     rs_data_q;
  logic [NB_DATA-1:0]     rt_data_q;
  logic [4:0]             shamt_q;
  logic [NB_IMM-1:0]      imm_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= OP_ADD;
      a_shamt_q <= 1'b0;
      b_src_q   <= B_RT;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      shamt_q   <= '0;
      imm_q     <= '0;
    end else if (bus.i_flush) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (bus.i_stall) begin
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= bus.i_valid & dec_legal;
      illegal_q <= bus.i_valid & ~dec_legal;
      op_q      <= dec_op;
      a_shamt_q <= dec_a_shamt;
      b_src_q   <= dec_b_src;
      wb_en_q   <= dec_wb & (dec_wb_addr != '0);
      wb_addr_q <= dec_wb_addr;
      rs_addr_q <= bus.i_rs_addr;
      rt_addr_q <= bus.i_rt_addr;
      rs_data_q <= bus.i_rs_data;
      rt_data_q <= bus.i_rt_data;
      shamt_q   <= bus.i_shamt;
      imm_q     <= bus.i_imm;
    end
  end

  // Forwarding looks at the live buses every cycle, so a stalled stage picks up late results.
  function automatic logic [NB_DATA-1:0] fwd_sel(
    input logic [NB_REG_ADDR-1:0] src,
    input logic [NB_DATA-1:0]     rf_data,
    input logic                   ex_en,
    input logic [NB_REG_ADDR-1:0] ex_addr,
    input logic [NB_DATA-1:0]     ex_res,
    input logic                   wb_en,
    input logic [NB_REG_ADDR-1:0] wb_addr,
    input logic [NB_DATA-1:0]     wb_res
  );
    if (ex_en && ex_addr != '0 && ex_addr == src) return ex_res;
    if (wb_en && wb_addr != '0 && wb_addr == src) return wb_res;
    return rf_data;
  endfunction

  logic [NB_DATA-1:0] rs_fwd;
  logic [NB_DATA-1:0] rt_fwd;

  always_comb begin
    rs_fwd = fwd_sel(rs_addr_q, rs_data_q, bus.i_exmem_wr_en, bus.i_exmem_rd_addr, bus.i_exmem_result,
                     bus.i_memwb_wr_en, bus.i_memwb_rd_addr, bus.i_memwb_result);
    rt_fwd = fwd_sel(rt_addr_q, rt_data_q, bus.i_exmem_wr_en, bus.i_exmem_rd_addr, bus.i_exmem_result,
                     bus.i_memwb_wr_en, bus.i_memwb_rd_addr, bus.i_memwb_result);
  end

  always_comb begin
    bus.o_data_a  = '0;
    bus.o_data_b  = '0;
    bus.o_op      = OP_ADD;
    bus.o_wb_en   = 1'b0;
    bus.o_valid   = valid_q;
    bus.o_illegal = illegal_q;
    bus.o_wb_addr = wb_addr_q;
    if (valid_q) begin
      bus.o_data_a = a_shamt_q ? NB_DATA'(shamt_q) : rs_fwd;
      case (b_src_q)
        B_SEXT:  bus.o_data_b = {{(NB_DATA-NB_IMM){imm_q[NB_IMM-1]}}, imm_q};
        B_ZEXT:  bus.o_data_b = NB_DATA'(imm_q);
        default: bus.o_data_b = rt_fwd;
      endcase
      bus.o_op    = op_q;
      bus.o_wb_en = wb_en_q;
    end
  end
endmodule
